inference_scheduler: RTL and testbench
======================================

INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12_000_000, clock frequency used to derive window length.
REQ-002 SHALL have parameter WINDOW_MS, default 400, inference window length in milliseconds.
REQ-003 SHALL have parameter MIN_EVENT_THRESH, default 20, minimum events per window for an inference to be launched.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles to wait for result_valid.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have ports: enable (in, 1, scheduling allowed); event_pulse (in, 1, one compressed event this cycle); force_trigger (in, 1, launch inference now).
REQ-008 SHALL have port result_valid, input, 1, classifier result available pulse.
REQ-009 SHALL have outputs: readout_start (1, single-cycle launch pulse); busy (1, inference in flight); skip_pulse (1, window closed below threshold).
REQ-010 SHALL have outputs: timeout_pulse (1, result wait expired); window_event_count (8, events in current window); inference_count (16, completed inferences); sched_state (2, current state code).

Function
REQ-011 SHALL derive WINDOW_CYCLES = (CLK_FREQ_HZ/1000)*WINDOW_MS; window counter width = $clog2(WINDOW_CYCLES).
REQ-012 SHALL implement states COLLECT=0, START=1, WAIT=2, DONE=3, exposed on sched_state.
REQ-013 COLLECT: window counter increments each cycle while enable=1; holds while enable=0.
REQ-014 COLLECT, counter == WINDOW_CYCLES-1: counter clears; if window_event_count >= MIN_EVENT_THRESH go START, else pulse skip_pulse one cycle and stay COLLECT.
REQ-015 COLLECT, force_trigger=1 and enable=1: go START next cycle regardless of threshold; window counter clears.
REQ-016 START: readout_start=1 for exactly this one cycle; next state WAIT; readout_start SHALL never be high outside START.
REQ-017 WAIT: result_valid=1 -> DONE; else wait counter increments.
REQ-018 DONE: inference_count increments (wraps at 2^16); next state COLLECT.
REQ-019 busy SHALL be 1 in START, WAIT, DONE and 0 in COLLECT.
REQ-020 window_event_count SHALL increment on event_pulse in every state, saturating at 255.
REQ-021 window_event_count SHALL clear on the cycle leaving COLLECT (threshold hit, skip or force); an event_pulse on that cycle loads 1, not 0.
REQ-022 Events arriving in START/WAIT/DONE SHALL count toward the next window.
REQ-023 result_valid in COLLECT or START SHALL be ignored (no count, no state change).
REQ-024 force_trigger outside COLLECT SHALL be ignored, not queued.
REQ-025 enable deasserted in START/WAIT/DONE SHALL NOT abort the in-flight inference.

Reset
REQ-026 On rst: state COLLECT; window, wait counters, window_event_count, inference_count = 0; readout_start, busy, skip_pulse, timeout_pulse = 0.
REQ-027 rst mid-WAIT SHALL abandon the inference with no inference_count increment; a result_valid in the reset cycle is ignored.

Configuration
REQ-028 With SCHED_TIMEOUT_EN defined: WAIT with wait counter == TIMEOUT_CYCLES-1 and no result_valid SHALL pulse timeout_pulse one cycle and return to COLLECT without incrementing inference_count; result_valid on that same cycle wins (DONE, no timeout).
REQ-029 Without SCHED_TIMEOUT_EN: no wait counter is built, WAIT exits only on result_valid, timeout_pulse tied 0.

Structure
REQ-030 Shared package dvs_sched_pkg SHALL hold the state enum type and a window-cycles constant function.
REQ-031 One sub-module sched_window_timer (counter, enable, clear, terminal pulse) SHALL be instantiated for the window counter; state machine stays in the top.

Verification (CLK_FREQ_HZ=1_000_000, WINDOW_MS=1 -> 1000 cycles, MIN_EVENT_THRESH=20, TIMEOUT_CYCLES=64)
REQ-032 25 events in window -> readout_start high exactly one cycle at cycle 1001 after reset release; busy high from then until DONE.
REQ-033 19 events in window -> skip_pulse one cycle at window end, no readout_start, window_event_count reads 0 next cycle.
REQ-034 force_trigger at cycle 100 with 3 events -> readout_start next cycle; result_valid 10 cycles later -> inference_count=1, state COLLECT.
REQ-035 SCHED_TIMEOUT_EN, no result_valid -> timeout_pulse 64 cycles into WAIT, inference_count stays 0; without macro, state holds WAIT indefinitely.
REQ-036 300 events in a window, plus event_pulse on clear cycle -> count saturates at 255, then reads 1; rst asserted in WAIT -> all outputs zero next cycle.

Source files
------------

// File: rtl/dvs_sched_pkg.sv
// -----------------------------------------------------------------------------
// dvs_sched_pkg
// Shared types and helpers for the inference scheduler.
//   sched_state_t  : scheduler state encoding (also driven on sched_state)
//   window_cycles(): window length in clock cycles from clock rate and ms
//   count_width()  : counter width for a modulo-N counter (minimum 1 bit)
// -----------------------------------------------------------------------------
package dvs_sched_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DONE    = 2'd3
  } sched_state_t;

  localparam logic [7:0] EVT_COUNT_MAX = 8'hFF;

  function automatic int unsigned window_cycles(input int unsigned clk_hz,
                                                input int unsigned win_ms);
    return (clk_hz / 1000) * win_ms;
  endfunction

  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_window_timer.sv
// -----------------------------------------------------------------------------
// sched_window_timer
// Free-running window counter that counts 0..CYCLES-1 while enabled, holds
// while disabled, and wraps to zero after the last count.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   i_en       : count this cycle
//   i_clr      : clear counter (wins over counting)
//   o_terminal : high on the enabled cycle the counter sits at CYCLES-1
// -----------------------------------------------------------------------------
module sched_window_timer #(
  parameter int unsigned CYCLES = 1000,
  parameter int unsigned WIDTH  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(CYCLES - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_terminal;

  assign w_terminal = i_en && (r_count == LAST);
  assign o_terminal = w_terminal;

  always_ff @(posedge clk) begin
    if (rst || i_clr || w_terminal) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/inference_scheduler.sv
// -----------------------------------------------------------------------------
// inference_scheduler
// Collects compressed events over a fixed window and launches a classifier
// readout when enough events arrived (or when forced), then waits for the
// classifier result.
// Optional feature: define SCHED_TIMEOUT_EN to build a result-wait timeout.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   enable             : window counting / triggering allowed
//   event_pulse        : one event this cycle
//   force_trigger      : launch now (only honoured in COLLECT with enable)
//   result_valid       : classifier result pulse (only honoured in WAIT)
//   readout_start      : one-cycle launch pulse (state START)
//   busy               : inference in flight (START/WAIT/DONE)
//   skip_pulse         : window closed below threshold
//   timeout_pulse      : result wait expired (0 unless SCHED_TIMEOUT_EN)
//   window_event_count : events in current window, saturating at 255
//   inference_count    : completed inferences, wraps at 2^16
//   sched_state        : current state code
// -----------------------------------------------------------------------------
module inference_scheduler
  import dvs_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 12_000_000,
  parameter int unsigned WINDOW_MS        = 400,
  parameter int unsigned MIN_EVENT_THRESH = 20,
  parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        event_pulse,
  input  logic        force_trigger,
  input  logic        result_valid,
  output logic        readout_start,
  output logic        busy,
  output logic        skip_pulse,
  output logic        timeout_pulse,
  output logic [7:0]  window_event_count,
  output logic [15:0] inference_count,
  output logic [1:0]  sched_state
);

  localparam int unsigned WINDOW_CYCLES = window_cycles(CLK_FREQ_HZ, WINDOW_MS);
  localparam int unsigned WIN_W         = count_width(WINDOW_CYCLES);
  // Thresholds above 255 can never be met by the saturating counter; the
  // extra bit keeps that case honest instead of truncating the threshold.
  localparam logic [8:0]  THRESH9       = (MIN_EVENT_THRESH > 255) ? 9'd256
                                                                   : 9'(MIN_EVENT_THRESH);

  sched_state_t r_state;
  sched_state_t w_state_next;
  logic [7:0]   r_evt_count;
  logic [15:0]  r_inf_count;
  logic         r_skip;
  logic         w_skip;
  logic         w_timer_en;
  logic         w_win_end;
  logic         w_force;
  logic         w_leave_window;
  logic         w_thresh_met;
  logic         w_wait_expired;

  assign w_timer_en     = (r_state == ST_COLLECT) && enable;
  assign w_force        = (r_state == ST_COLLECT) && enable && force_trigger;
  assign w_leave_window = w_force || w_win_end;
  assign w_thresh_met   = ({1'b0, r_evt_count} >= THRESH9);

  sched_window_timer #(
    .CYCLES (WINDOW_CYCLES),
    .WIDTH  (WIN_W)
  ) u_window_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_timer_en),
    .i_clr      (w_force),
    .o_terminal (w_win_end)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned     WAIT_W    = count_width(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic              w_timeout;

  assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
  assign w_timeout      = (r_state == ST_WAIT) && !result_valid && w_wait_expired;
  assign timeout_pulse  = r_timeout;

  // Counts cycles spent in WAIT; parked at zero everywhere else so each
  // inference starts its wait budget fresh.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_WAIT)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
    end
  end
`else
  assign w_wait_expired = 1'b0;
  assign timeout_pulse  = 1'b0;

  // No wait counter in this build; TIMEOUT_CYCLES is kept only so the
  // parameter list is identical in both builds.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_skip       = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_force) begin
          w_state_next = ST_START;
        end else if (w_win_end) begin
          if (w_thresh_met) begin
            w_state_next = ST_START;
          end else begin
            w_skip = 1'b1;
          end
        end
      end
      ST_START: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // A result on the expiry cycle still counts as a completion.
        if (result_valid) begin
          w_state_next = ST_DONE;
        end else if (w_wait_expired) begin
          w_state_next = ST_COLLECT;
        end
      end
      ST_DONE: w_state_next = ST_COLLECT;
      default: w_state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_evt_count <= 8'd0;
      r_inf_count <= 16'd0;
      r_skip      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_skip  <= w_skip;
      // Leaving the window restarts the count; an event arriving on that
      // very cycle belongs to the new window.
      if (w_leave_window) begin
        r_evt_count <= event_pulse ? 8'd1 : 8'd0;
      end else if (event_pulse && (r_evt_count != EVT_COUNT_MAX)) begin
        r_evt_count <= r_evt_count + 8'd1;
      end
      if (r_state == ST_DONE) begin
        r_inf_count <= r_inf_count + 16'd1;
      end
    end
  end

  assign readout_start      = (r_state == ST_START);
  assign busy               = (r_state != ST_COLLECT);
  assign skip_pulse         = r_skip;
  assign window_event_count = r_evt_count;
  assign inference_count    = r_inf_count;
  assign sched_state        = r_state;

endmodule

// File: tb/tb_inference_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inference_scheduler
// Self-checking bench for inference_scheduler with a 1000-cycle window,
// threshold 20 and a 64-cycle result timeout. Cycle c is the c-th clock
// period after reset release; outputs are sampled 1 time unit after edge c.
// Expected output pulses are queued as stimulus is planned and matched
// against observed pulses.
// -----------------------------------------------------------------------------
module tb_inference_scheduler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        event_pulse;
  logic        force_trigger;
  logic        result_valid;
  logic        readout_start;
  logic        busy;
  logic        skip_pulse;
  logic        timeout_pulse;
  logic [7:0]  window_event_count;
  logic [15:0] inference_count;
  logic [1:0]  sched_state;

  typedef struct packed {
    int kind;   // 1 readout_start, 2 skip_pulse, 3 timeout_pulse
    int cycle;
  } pulse_t;

  pulse_t sb_q[$];
  pulse_t obs_q[$];
  logic [7:0] cnt_log[0:1200];
  logic [1:0] state_log[0:1200];

  int n_checks;
  int n_pass;

  inference_scheduler #(
    .CLK_FREQ_HZ      (1_000_000),
    .WINDOW_MS        (1),
    .MIN_EVENT_THRESH (20),
    .TIMEOUT_CYCLES   (64)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .event_pulse        (event_pulse),
    .force_trigger      (force_trigger),
    .result_valid       (result_valid),
    .readout_start      (readout_start),
    .busy               (busy),
    .skip_pulse         (skip_pulse),
    .timeout_pulse      (timeout_pulse),
    .window_event_count (window_event_count),
    .inference_count    (inference_count),
    .sched_state        (sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_hold();
    rst           = 1'b1;
    enable        = 1'b0;
    event_pulse   = 1'b0;
    force_trigger = 1'b0;
    result_valid  = 1'b0;
    tick();
    tick();
  endtask

  // Drives cycles base+1..base+n with events on c<=ev_until or c>=ev_from,
  // logging count/state per cycle and every output pulse observed.
  task automatic run_cycles(input int n, input int ev_until, input int ev_from, input int base);
    for (int c = base + 1; c <= base + n; c++) begin
      event_pulse = (c <= ev_until) || (c >= ev_from);
      tick();
      cnt_log[c]   = window_event_count;
      state_log[c] = sched_state;
      if (readout_start) obs_q.push_back('{kind: 1, cycle: c});
      if (skip_pulse)    obs_q.push_back('{kind: 2, cycle: c});
      if (timeout_pulse) obs_q.push_back('{kind: 3, cycle: c});
    end
    event_pulse = 1'b0;
  endtask

  task automatic test_reset();
    reset_hold();
    event_pulse = 1'b1;
    tick();
    event_pulse = 1'b0;
    n_checks++;
    if ({readout_start, busy, skip_pulse, timeout_pulse} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {readout_start, busy, skip_pulse, timeout_pulse});
    else n_pass++;
    n_checks++;
    if (window_event_count !== 8'd0) $display("FAIL reset_evt_count got %0d want 0", window_event_count);
    else n_pass++;
    n_checks++;
    if (inference_count !== 16'd0) $display("FAIL reset_inf_count got %0d want 0", inference_count);
    else n_pass++;
    n_checks++;
    if (sched_state !== 2'd0) $display("FAIL reset_state got %0d want 0", sched_state);
    else n_pass++;
    $display("test_reset: outputs sampled under reset");
  endtask

  task automatic test_threshold_hit();
    pulse_t got;
    pulse_t exp;
    bit     busy_ok;
    reset_hold();
    obs_q.delete();
    sb_q.push_back('{kind: 1, cycle: 1000});
    rst    = 1'b0;
    enable = 1'b1;
    run_cycles(1001, 25, 100000, 0);
    n_checks++;
    if (obs_q.size() !== 1) $display("FAIL hit_pulse_count got %0d want 1", obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0 && sb_q.size() > 0) begin
      got = obs_q.pop_front();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL hit_readout got kind %0d cycle %0d want kind %0d cycle %0d", got.kind, got.cycle, exp.kind, exp.cycle);
      else n_pass++;
    end
    sb_q.delete();
    n_checks++;
    if (cnt_log[999] !== 8'd25 || cnt_log[1000] !== 8'd0) $display("FAIL hit_evt_count got %0d/%0d want 25/0", cnt_log[999], cnt_log[1000]);
    else n_pass++;
    busy_ok = (state_log[1001] == 2'd2) && busy;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (!busy || sched_state != 2'd2 || readout_start) busy_ok = 1'b0;
    end
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    if (!busy || sched_state != 2'd3) busy_ok = 1'b0;
    n_checks++;
    if (!busy_ok) $display("FAIL hit_busy_wait_done got state %0d busy %b want busy through DONE", sched_state, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (sched_state !== 2'd0 || busy !== 1'b0 || inference_count !== 16'd1) $display("FAIL hit_complete got state %0d busy %b inf %0d want 0 0 1", sched_state, busy, inference_count);
    else n_pass++;
    $display("test_threshold_hit: 25 events, readout at cycle 1000 sample");
  endtask

  task automatic test_skip();
    pulse_t got;
    pulse_t exp;
    reset_hold();
    obs_q.delete();
    sb_q.push_back('{kind: 2, cycle: 1000});
    rst    = 1'b0;
    enable = 1'b1;
    run_cycles(1002, 19, 100000, 0);
    n_checks++;
    if (obs_q.size() !== 1) $display("FAIL skip_pulse_count got %0d want 1", obs_q.size());
    else n_pass++;
    if (obs_q.size() > 0 && sb_q.size() > 0) begin
      got = obs_q.pop_front();
      exp = sb_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL skip_pulse got kind %0d cycle %0d want kind %0d cycle %0d", got.kind, got.cycle, exp.kind, exp.cycle);
      else n_pass++;
    end
    sb_q.delete();
    n_checks++;
    if (cnt_log[999] !== 8'd19 || cnt_log[1000] !== 8'd0 || state_log[1000] !== 2'd0) $display("FAIL skip_after got cnt %0d/%0d state %0d want 19/0 0", cnt_log[999], cnt_log[1000], state_log[1000]);
    else n_pass++;
    $display("test_skip: 19 events, window skipped");
  endtask

  task automatic test_force();
    bit wait_ok;
    reset_hold();
    obs_q.delete();
    rst    = 1'b0;
    enable = 1'b1;
    run_cycles(98, 3, 100000, 0);
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    n_checks++;
    if (sched_state !== 2'd0 || inference_count !== 16'd0 || cnt_log[98] !== 8'd3) $display("FAIL force_rv_in_collect got state %0d inf %0d cnt %0d want 0 0 3", sched_state, inference_count, cnt_log[98]);
    else n_pass++;
    force_trigger = 1'b1;
    tick();
    force_trigger = 1'b0;
    n_checks++;
    if (readout_start !== 1'b1 || sched_state !== 2'd1 || window_event_count !== 8'd0) $display("FAIL force_start got rs %b state %0d cnt %0d want 1 1 0", readout_start, sched_state, window_event_count);
    else n_pass++;
    tick();
    wait_ok = (sched_state == 2'd2);
    for (int c = 102; c <= 105; c++) begin
      enable        = 1'b0;
      force_trigger = 1'b1;
      tick();
      if (sched_state != 2'd2 || readout_start) wait_ok = 1'b0;
    end
    enable        = 1'b1;
    force_trigger = 1'b0;
    n_checks++;
    if (!wait_ok) $display("FAIL force_wait_hold got state %0d rs %b want 2 0", sched_state, readout_start);
    else n_pass++;
    for (int c = 106; c <= 109; c++) tick();
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    n_checks++;
    if (sched_state !== 2'd3) $display("FAIL force_done got state %0d want 3", sched_state);
    else n_pass++;
    tick();
    n_checks++;
    if (sched_state !== 2'd0 || inference_count !== 16'd1) $display("FAIL force_complete got state %0d inf %0d want 0 1", sched_state, inference_count);
    else n_pass++;
    $display("test_force: forced launch at cycle 100, result at 110");
  endtask

  task automatic test_reset_in_wait();
    event_pulse   = 1'b1;
    force_trigger = 1'b1;
    tick();
    force_trigger = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (sched_state !== 2'd2 || window_event_count === 8'd0) $display("FAIL rstwait_setup got state %0d cnt %0d want 2 nonzero", sched_state, window_event_count);
    else n_pass++;
    rst          = 1'b1;
    result_valid = 1'b1;
    tick();
    n_checks++;
    if ({readout_start, busy, skip_pulse, timeout_pulse, window_event_count, inference_count, sched_state} !== 30'd0)
      $display("FAIL rstwait_zero got rs %b busy %b skip %b to %b cnt %0d inf %0d state %0d want all 0", readout_start, busy, skip_pulse, timeout_pulse, window_event_count, inference_count, sched_state);
    else n_pass++;
    rst          = 1'b0;
    result_valid = 1'b0;
    event_pulse  = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sched_state !== 2'd0 || inference_count !== 16'd0) $display("FAIL rstwait_after got state %0d inf %0d want 0 0", sched_state, inference_count);
    else n_pass++;
    $display("test_reset_in_wait: inference abandoned by reset");
  endtask

  task automatic test_timeout();
    int     wait_n;
    int     c;
    pulse_t got;
    pulse_t exp;
    reset_hold();
    obs_q.delete();
    rst           = 1'b0;
    enable        = 1'b1;
    force_trigger = 1'b1;
    tick();
    force_trigger = 1'b0;
    c      = 1;
    wait_n = 0;
`ifdef SCHED_TIMEOUT_EN
    sb_q.push_back('{kind: 3, cycle: 66});
`endif
    for (int k = 0; k < 200; k++) begin
      tick();
      c++;
      if (timeout_pulse) obs_q.push_back('{kind: 3, cycle: c});
      if (sched_state != 2'd2) break;
      wait_n++;
    end
`ifdef SCHED_TIMEOUT_EN
    n_checks++;
    if (wait_n !== 64) $display("FAIL timeout_wait_len got %0d want 64", wait_n);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 1 || sb_q.size() !== 1) $display("FAIL timeout_pulse_count got %0d want 1", obs_q.size());
    else begin
      got = obs_q.pop_front();
      exp = sb_q.pop_front();
      if (got !== exp) $display("FAIL timeout_pulse got cycle %0d want %0d", got.cycle, exp.cycle);
      else n_pass++;
    end
    sb_q.delete();
    n_checks++;
    if (sched_state !== 2'd0 || inference_count !== 16'd0) $display("FAIL timeout_after got state %0d inf %0d want 0 0", sched_state, inference_count);
    else n_pass++;
    tick();
    n_checks++;
    if (timeout_pulse !== 1'b0) $display("FAIL timeout_one_cycle got %b want 0", timeout_pulse);
    else n_pass++;
`else
    n_checks++;
    if (wait_n !== 200 || sched_state !== 2'd2) $display("FAIL no_timeout_hold got wait %0d state %0d want 200 2", wait_n, sched_state);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 0 || timeout_pulse !== 1'b0) $display("FAIL no_timeout_pulse got %0d pulses want 0", obs_q.size());
    else n_pass++;
`endif
    $display("test_timeout: waited %0d cycles in WAIT", wait_n);
  endtask

  task automatic test_saturation();
    pulse_t got;
    pulse_t exp;
    reset_hold();
    obs_q.delete();
    sb_q.push_back('{kind: 1, cycle: 1000});
    rst    = 1'b0;
    enable = 1'b1;
    run_cycles(1001, 300, 1000, 0);
    n_checks++;
    if (cnt_log[254] !== 8'd254 || cnt_log[300] !== 8'd255 || cnt_log[999] !== 8'd255) $display("FAIL sat_count got %0d/%0d/%0d want 254/255/255", cnt_log[254], cnt_log[300], cnt_log[999]);
    else n_pass++;
    n_checks++;
    if (cnt_log[1000] !== 8'd1) $display("FAIL sat_clear_load got %0d want 1", cnt_log[1000]);
    else n_pass++;
    n_checks++;
    if (cnt_log[1001] !== 8'd2) $display("FAIL sat_start_event got %0d want 2", cnt_log[1001]);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== 1 || sb_q.size() !== 1) $display("FAIL sat_pulse_count got %0d want 1", obs_q.size());
    else begin
      got = obs_q.pop_front();
      exp = sb_q.pop_front();
      if (got !== exp) $display("FAIL sat_readout got kind %0d cycle %0d want kind %0d cycle %0d", got.kind, got.cycle, exp.kind, exp.cycle);
      else n_pass++;
    end
    sb_q.delete();
    $display("test_saturation: 300 events plus clear-cycle event");
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    enable        = 1'b0;
    event_pulse   = 1'b0;
    force_trigger = 1'b0;
    result_valid  = 1'b0;
    test_reset();
    test_threshold_hit();
    test_skip();
    test_force();
    test_reset_in_wait();
    test_timeout();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
